dest_track_pipe: RTL and testbench
==================================

// Module: dest_track_pipe
// PURPOSE
//  Producer side of the operand-forwarding interface. Carries destination-register info
//  (rd, reg_write, mem_read) through the EX->MEM->WB pipeline registers.
//  Drives mem_rd/mem_reg_write/wb_rd/wb_reg_write into forwarding_unit.
//  Owns the EX-stage hold for multicycle ops and the load-use hazard stall/bubble request.
// PARAMETERS
//  REG_ADDR_W   5   register-index width
//  MUL_LATENCY  3   EX-stage cycles a multicycle op occupies (>=1; 1 = no hold)
// PORTS
//  clk            in   1           pipeline clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  ex_valid       in   1           ID/EX register holds a real instruction
//  ex_rd          in   REG_ADDR_W  EX-stage destination register
//  ex_reg_write   in   1           EX instruction writes rd
//  ex_mem_read    in   1           EX instruction is a load
//  ex_multi       in   1           EX instruction is a multicycle op
//  ex_flush       in   1           kill EX instruction (branch redirect)
//  id_rs1         in   REG_ADDR_W  ID-stage source 1
//  id_rs2         in   REG_ADDR_W  ID-stage source 2
//  stall_id       out  1           hold PC, IF/ID (and ID/EX when busy)
//  id_ex_bubble   out  1           load ID/EX with a bubble next edge
//  ex_busy        out  1           multicycle op in progress (state BUSY)
//  mem_rd         out  REG_ADDR_W  EX/MEM destination
//  mem_reg_write  out  1           EX/MEM write enable
//  mem_mem_read   out  1           EX/MEM is a load
//  wb_rd          out  REG_ADDR_W  MEM/WB destination
//  wb_reg_write   out  1           MEM/WB write enable
// BEHAVIOUR
//  - Reset (async, rst=1): all MEM/WB registers 0; cnt=0; state IDLE.
//    stall_id, id_ex_bubble and ex_busy deassert immediately (ex_busy reflects state).
//  - State machine: IDLE (cnt==0) / BUSY (cnt>0).
//    cnt counts elapsed EX cycles of the current multicycle op.
//  - ex_done = !ex_multi | (cnt == MUL_LATENCY-1).
//  - Per edge, priority order:
//    1. ex_flush: MEM <= bubble; cnt <= 0. Flush wins over BUSY.
//    2. ex_valid & !ex_done: cnt <= cnt+1; MEM <= bubble.
//    3. Otherwise: cnt <= 0; MEM <= EX fields if ex_valid, else bubble.
//  - Bubble = rd 0, reg_write 0, mem_read 0.
//  - reg_write into MEM is qualified with (ex_rd != 0). x0 is never advertised as written.
//  - WB <= MEM unconditionally every edge. No downstream stall exists.
//  - Latency: EX fields appear on mem_* 1 edge after acceptance and on wb_* after 2.
//    A multicycle op appears on mem_* MUL_LATENCY edges after first entering EX.
//  - load_use = ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & !ex_flush
//               & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  - stall_id = load_use | (ex_valid & !ex_done & !ex_flush). Combinational.
//  - id_ex_bubble = load_use only. During BUSY, ID/EX holds (stall, no bubble).
//    Upstream keeps ex_* stable while busy.
//  - Load + multi on the same instruction is illegal; behaviour undefined.
//  - MUL_LATENCY=1: ex_done is always 1 and BUSY is never entered.
//  - cnt is $clog2(MUL_LATENCY)+1 bits wide, so it never wraps.
// STRUCTURE
//  - Shared header cpu_defs.vh: REG_ADDR_W, REG_ZERO (5'd0), IDLE/BUSY state encodings.
//  - One sub-module: ex_multicycle_ctr (cnt, ex_done, ex_busy).
//  - Top level holds the stage registers and the hazard logic.
// TESTING
//  1. Reset mid-BUSY (cnt=1), rst=1 -> all outputs 0 at once; after release, state IDLE.
//  2. ALU op rd=5, reg_write=1 -> mem_rd=5, mem_reg_write=1 next edge;
//     wb_rd=5, wb_reg_write=1 one edge later.
//  3. rd=0, reg_write=1 -> mem_reg_write=0 and wb_reg_write=0.
//  4. Load rd=3 in EX, id_rs2=3 -> stall_id=1 and id_ex_bubble=1 same cycle; MEM gets rd=3, mem_read=1.
//     Load rd=3, id_rs1=id_rs2=4 -> no stall.
//  5. Multi op rd=7, MUL_LATENCY=3 -> stall_id=1 and id_ex_bubble=0 for 2 cycles, ex_busy=1 on the 2nd;
//     MEM shows 2 bubbles, then mem_rd=7 on the 3rd edge.
//  6. Multi op with ex_flush on its 2nd cycle -> stall drops at once; MEM bubble; cnt=0, IDLE.

Source files
------------

// File: rtl/dest_track_pipe_pkg.sv
// Shared definitions for the destination-tracking pipeline: register-index
// width, the zero register, EX-stage state encoding and the per-stage record.
package dest_track_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // EX-stage occupancy: IDLE while cnt==0, BUSY while a multicycle op is mid-flight.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_e;

  // Destination info carried down the EX->MEM->WB registers.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } dest_info_t;

  // A bubble advertises nothing: rd 0, no write, no load.
  function automatic dest_info_t bubble_info();
    return '0;
  endfunction

endpackage

// File: rtl/dest_track_pipe_if.sv
// Bundle between the decode/execute control and the destination tracker.
// The master side owns the ex_*/id_* fields; the slave (tracker) drives the
// hazard requests and the MEM/WB destination info used by forwarding.
interface dest_track_pipe_if;
  import dest_track_pipe_pkg::*;

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_multi;
  logic                  ex_flush;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;

  logic                  stall_id;
  logic                  id_ex_bubble;
  logic                  ex_busy;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;

  modport master (
    output ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_multi, ex_flush,
    output id_rs1, id_rs2,
    input  stall_id, id_ex_bubble, ex_busy,
    input  mem_rd, mem_reg_write, mem_mem_read, wb_rd, wb_reg_write
  );

  modport slave (
    input  ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_multi, ex_flush,
    input  id_rs1, id_rs2,
    output stall_id, id_ex_bubble, ex_busy,
    output mem_rd, mem_reg_write, mem_mem_read, wb_rd, wb_reg_write
  );

endinterface

// File: rtl/dest_track_pipe_ex_multicycle_ctr.sv
// EX-stage occupancy counter for multicycle ops. cnt counts the EX cycles
// already spent by the current op; ex_done marks its final EX cycle.
module ex_multicycle_ctr
  import dest_track_pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_valid,
  input  logic ex_multi,
  input  logic ex_flush,
  output logic ex_done,
  output logic ex_busy
);

  // One extra bit over what MUL_LATENCY-1 needs, so the count never wraps.
  localparam int CW = $clog2(MUL_LATENCY) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_LATENCY - 1);

  ex_state_e       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  assign ex_done = !ex_multi || (cnt_reg == LAST_CNT);
  assign ex_busy = (state_reg == BUSY);

  // State and count registers; reset returns to IDLE with an empty count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A flush kills the op outright; otherwise advance only while an unfinished op holds EX.
  always_comb begin
    cnt_next   = '0;
    state_next = IDLE;
    if (!ex_flush && ex_valid && !ex_done) begin
      cnt_next   = cnt_reg + CW'(1);
      state_next = BUSY;
    end
  end

endmodule

// File: rtl/dest_track_pipe.sv
// Producer side of operand forwarding: carries rd/reg_write/mem_read through
// the EX/MEM and MEM/WB registers and raises the ID stall / ID-EX bubble for
// load-use hazards and for multicycle ops occupying EX.
module dest_track_pipe
  import dest_track_pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  dest_track_pipe_if.slave   bus
);

  logic                  ex_done;
  logic                  ex_busy_w;
  logic                  hold_multi;
  logic                  load_use;
  dest_info_t            ex_info;
  dest_info_t            mem_next;
  dest_info_t            mem_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;
  logic                  wb_reg_write_reg;

  ex_multicycle_ctr #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_ex_ctr (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (bus.ex_valid),
    .ex_multi (bus.ex_multi),
    .ex_flush (bus.ex_flush),
    .ex_done  (ex_done),
    .ex_busy  (ex_busy_w)
  );

  // An unfinished multicycle op must keep EX occupied unless it is being killed.
  assign hold_multi = bus.ex_valid && !ex_done && !bus.ex_flush;

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign load_use = bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write &&
                    (bus.ex_rd != REG_ZERO) && !bus.ex_flush &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  // Requests are forced low during reset so upstream is released immediately.
  assign bus.stall_id     = !rst && (load_use || hold_multi);
  assign bus.id_ex_bubble = !rst && load_use;
  assign bus.ex_busy      = ex_busy_w;

  // Select what the EX/MEM register captures; x0 is never advertised as written.
  always_comb begin
    ex_info.rd        = bus.ex_rd;
    ex_info.reg_write = bus.ex_reg_write && (bus.ex_rd != REG_ZERO);
    ex_info.mem_read  = bus.ex_mem_read;
    mem_next          = bubble_info();
    if (!bus.ex_flush && bus.ex_valid && ex_done) begin
      mem_next = ex_info;
    end
  end

  // Stage registers; WB follows MEM every edge since nothing downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reg          <= bubble_info();
      wb_rd_reg        <= REG_ZERO;
      wb_reg_write_reg <= 1'b0;
    end else begin
      mem_reg          <= mem_next;
      wb_rd_reg        <= mem_reg.rd;
      wb_reg_write_reg <= mem_reg.reg_write;
    end
  end

  assign bus.mem_rd        = mem_reg.rd;
  assign bus.mem_reg_write = mem_reg.reg_write;
  assign bus.mem_mem_read  = mem_reg.mem_read;
  assign bus.wb_rd         = wb_rd_reg;
  assign bus.wb_reg_write  = wb_reg_write_reg;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Bench for dest_track_pipe: a table of single-instruction vectors, hand-built
// multicycle/flush/reset sequences, then random traffic against a queue model.
module tb_dest_track_pipe;
  import dest_track_pipe_pkg::*;

  localparam int LAT = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mu;
    logic       fl;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } vin_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic [4:0] mrd;
    logic       mrw;
    logic       mmr;
  } vexp_t;

  typedef struct packed {
    vin_t  in;
    vexp_t ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  dest_track_pipe_if bus ();

  dest_track_pipe #(.MUL_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endfunction

  task automatic set_in(input vin_t x);
    bus.ex_valid     = x.v;
    bus.ex_rd        = x.rd;
    bus.ex_reg_write = x.rw;
    bus.ex_mem_read  = x.mr;
    bus.ex_multi     = x.mu;
    bus.ex_flush     = x.fl;
    bus.id_rs1       = x.rs1;
    bus.id_rs2       = x.rs2;
  endtask

  // ---------------- reference model ----------------
  // An instruction needs LAT EX cycles if multicycle, else 1. m_spent is how many
  // cycles the current one has already sat in EX. MEM/WB is a 2-deep shift queue.
  int         m_spent;
  dest_info_t m_q[$];

  function automatic void m_reset();
    m_spent = 0;
    m_q = {};
    m_q.push_back('0);
    m_q.push_back('0);
  endfunction

  function automatic logic m_load_use(input vin_t x);
    return x.v && x.mr && x.rw && x.rd != 0 && !x.fl && (x.rd == x.rs1 || x.rd == x.rs2);
  endfunction

  function automatic logic m_stall(input vin_t x);
    int need = x.mu ? LAT : 1;
    return m_load_use(x) || (x.v && !x.fl && (m_spent + 1 < need));
  endfunction

  function automatic void m_edge(input vin_t x);
    int need = x.mu ? LAT : 1;
    dest_info_t enter = '0;
    if (x.v && !x.fl) begin
      if (m_spent + 1 < need) m_spent++;
      else begin
        m_spent = 0;
        enter.rd = x.rd;
        enter.reg_write = x.rw && (x.rd != 0);
        enter.mem_read = x.mr;
      end
    end else begin
      m_spent = 0;
    end
    m_q.push_front(enter);
    void'(m_q.pop_back());
  endfunction

  // ---------------- stimulus ----------------
  vec_t tbl[12];
  vin_t idle_in;
  vin_t cur;
  vin_t tmp;

  initial begin
    idle_in = '0;
    //          v  rd   rw mr mu fl rs1  rs2    stall bub mrd  mrw mmr
    tbl[0]  = {{1'b1,5'd5 ,1'b1,1'b0,1'b0,1'b0,5'd1 ,5'd2 },{1'b0,1'b0,5'd5 ,1'b1,1'b0}};
    tbl[1]  = {{1'b1,5'd0 ,1'b1,1'b0,1'b0,1'b0,5'd0 ,5'd0 },{1'b0,1'b0,5'd0 ,1'b0,1'b0}};
    tbl[2]  = {{1'b1,5'd3 ,1'b1,1'b1,1'b0,1'b0,5'd1 ,5'd3 },{1'b1,1'b1,5'd3 ,1'b1,1'b1}};
    tbl[3]  = {{1'b1,5'd3 ,1'b1,1'b1,1'b0,1'b0,5'd4 ,5'd4 },{1'b0,1'b0,5'd3 ,1'b1,1'b1}};
    tbl[4]  = {{1'b1,5'd3 ,1'b1,1'b1,1'b0,1'b1,5'd3 ,5'd0 },{1'b0,1'b0,5'd0 ,1'b0,1'b0}};
    tbl[5]  = {{1'b1,5'd0 ,1'b1,1'b1,1'b0,1'b0,5'd0 ,5'd0 },{1'b0,1'b0,5'd0 ,1'b0,1'b1}};
    tbl[6]  = {{1'b1,5'd3 ,1'b0,1'b1,1'b0,1'b0,5'd3 ,5'd0 },{1'b0,1'b0,5'd3 ,1'b0,1'b1}};
    tbl[7]  = {{1'b0,5'd3 ,1'b1,1'b1,1'b0,1'b0,5'd3 ,5'd3 },{1'b0,1'b0,5'd0 ,1'b0,1'b0}};
    tbl[8]  = {{1'b1,5'd7 ,1'b1,1'b0,1'b1,1'b0,5'd0 ,5'd0 },{1'b1,1'b0,5'd0 ,1'b0,1'b0}};
    tbl[9]  = {{1'b1,5'd7 ,1'b1,1'b0,1'b1,1'b1,5'd0 ,5'd0 },{1'b0,1'b0,5'd0 ,1'b0,1'b0}};
    tbl[10] = {{1'b1,5'd31,1'b1,1'b0,1'b0,1'b0,5'd31,5'd31},{1'b0,1'b0,5'd31,1'b1,1'b0}};
    tbl[11] = {{1'b1,5'd9 ,1'b0,1'b0,1'b0,1'b0,5'd0 ,5'd0 },{1'b0,1'b0,5'd9 ,1'b0,1'b0}};

    set_in(idle_in);
    #2;
    chk("rst_stall", bus.stall_id, 0);
    chk("rst_busy", bus.ex_busy, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_wb_rw", bus.wb_reg_write, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector for one cycle, then an idle cycle to see it reach WB.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(tbl[i].in);
      #1;
      chk($sformatf("v%0d_stall", i), bus.stall_id, tbl[i].ex.stall);
      chk($sformatf("v%0d_bubble", i), bus.id_ex_bubble, tbl[i].ex.bubble);
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_rd", i), bus.mem_rd, tbl[i].ex.mrd);
      chk($sformatf("v%0d_mem_rw", i), bus.mem_reg_write, tbl[i].ex.mrw);
      chk($sformatf("v%0d_mem_mr", i), bus.mem_mem_read, tbl[i].ex.mmr);
      @(negedge clk);
      set_in(idle_in);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_rd", i), bus.wb_rd, tbl[i].ex.mrd);
      chk($sformatf("v%0d_wb_rw", i), bus.wb_reg_write, tbl[i].ex.mrw);
    end

    // Multicycle op rd=7 held for LAT cycles.
    tmp = '0; tmp.v = 1; tmp.rd = 7; tmp.rw = 1; tmp.mu = 1;
    @(negedge clk); set_in(tmp); #1;
    chk("mul_c1_stall", bus.stall_id, 1);
    chk("mul_c1_bubble", bus.id_ex_bubble, 0);
    chk("mul_c1_busy", bus.ex_busy, 0);
    @(posedge clk); #1;
    chk("mul_e1_mem_rd", bus.mem_rd, 0);
    @(negedge clk); #1;
    chk("mul_c2_stall", bus.stall_id, 1);
    chk("mul_c2_bubble", bus.id_ex_bubble, 0);
    chk("mul_c2_busy", bus.ex_busy, 1);
    @(posedge clk); #1;
    chk("mul_e2_mem_rw", bus.mem_reg_write, 0);
    @(negedge clk); #1;
    chk("mul_c3_stall", bus.stall_id, 0);
    @(posedge clk); #1;
    chk("mul_e3_mem_rd", bus.mem_rd, 7);
    chk("mul_e3_mem_rw", bus.mem_reg_write, 1);
    chk("mul_e3_busy", bus.ex_busy, 0);
    @(negedge clk); set_in(idle_in);
    @(posedge clk); #1;
    chk("mul_wb_rd", bus.wb_rd, 7);

    // Multicycle op killed by a flush on its second cycle.
    tmp.rd = 6;
    @(negedge clk); set_in(tmp);
    @(posedge clk); #1;
    chk("fl_busy", bus.ex_busy, 1);
    @(negedge clk); tmp.fl = 1; set_in(tmp); #1;
    chk("fl_stall", bus.stall_id, 0);
    chk("fl_bubble", bus.id_ex_bubble, 0);
    @(posedge clk); #1;
    chk("fl_mem_rd", bus.mem_rd, 0);
    chk("fl_mem_rw", bus.mem_reg_write, 0);
    chk("fl_busy_after", bus.ex_busy, 0);
    @(negedge clk); set_in(idle_in);

    // Reset asserted while a multicycle op is BUSY and WB holds a real entry.
    tmp = '0; tmp.v = 1; tmp.rd = 9; tmp.rw = 1;
    @(negedge clk); set_in(tmp);
    tmp.rd = 7; tmp.mu = 1;
    @(negedge clk); set_in(tmp);
    @(posedge clk); #1;
    chk("rb_pre_busy", bus.ex_busy, 1);
    chk("rb_pre_wb_rd", bus.wb_rd, 9);
    @(negedge clk); rst = 1'b1; #1;
    chk("rb_busy", bus.ex_busy, 0);
    chk("rb_stall", bus.stall_id, 0);
    chk("rb_bubble", bus.id_ex_bubble, 0);
    chk("rb_wb_rd", bus.wb_rd, 0);
    chk("rb_wb_rw", bus.wb_reg_write, 0);
    chk("rb_mem_mr", bus.mem_mem_read, 0);
    @(negedge clk); rst = 1'b0; set_in(idle_in);
    @(posedge clk); #1;
    chk("rb_idle_busy", bus.ex_busy, 0);
    @(negedge clk); #1;
    chk("rb_idle_stall", bus.stall_id, 0);

    // Random traffic against the model; ex_* held stable while an op is mid-flight.
    m_reset();
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (m_spent == 0) begin
        cur.v   = ($urandom_range(0, 9) < 8);
        cur.rd  = 5'($urandom_range(0, 7));
        cur.rw  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: begin cur.mr = 0; cur.mu = 0; end
          1: begin cur.mr = 1; cur.mu = 0; end
          default: begin cur.mr = 0; cur.mu = 1; end
        endcase
      end
      cur.fl  = ($urandom_range(0, 9) == 0);
      cur.rs1 = 5'($urandom_range(0, 7));
      cur.rs2 = 5'($urandom_range(0, 7));
      set_in(cur);
      #1;
      chk("rnd_stall", bus.stall_id, m_stall(cur));
      chk("rnd_bubble", bus.id_ex_bubble, m_load_use(cur));
      chk("rnd_busy", bus.ex_busy, (m_spent > 0));
      @(posedge clk);
      m_edge(cur);
      #1;
      chk("rnd_mem_rd", bus.mem_rd, m_q[0].rd);
      chk("rnd_mem_rw", bus.mem_reg_write, m_q[0].reg_write);
      chk("rnd_mem_mr", bus.mem_mem_read, m_q[0].mem_read);
      chk("rnd_wb_rd", bus.wb_rd, m_q[1].rd);
      chk("rnd_wb_rw", bus.wb_reg_write, m_q[1].reg_write);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
